// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED PWM fader.
//   PWM_BITS_DEF / MAX_DEF : default brightness resolution and full-scale level
//   level_t                : brightness level type at the default resolution
//   sat_step()             : saturating linear fade step used by every channel
package led_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int MAX_DEF      = (1 << PWM_BITS_DEF) - 1;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Moves level one fade step toward max_val (up=1) or toward 0 (up=0),
  // clamping at either end. The work is done 32 bits wide so the sum can
  // never wrap for any legal PWM_BITS; callers narrow the result back down.
  function automatic logic [31:0] sat_step(input logic [31:0] level,
                                           input logic        up,
                                           input logic [31:0] step,
                                           input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, level} + {1'b0, step};
    if (up) begin
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    end
    return (level > step) ? (level - step) : 32'd0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED channel of the fader.
//   hwclk, rst : clock and synchronous active-high reset
//   enable     : 0 blanks the pin on the next edge
//   tick       : fade step strobe; target is sampled only while it is high
//   target     : 1 = fade toward full scale, 0 = fade toward off
//   pwm_cnt    : shared free-running PWM counter
//   pin        : registered PWM drive
// Optional build macro LED_PWM_FADER_GAMMA_EN squares the level before the
// PWM compare for perceptually linear fades.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int FADE_STEP = 4
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic                enable,
  input  logic                tick,
  input  logic                target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pin
);

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] level_eff;

  assign level_next = PWM_BITS'(sat_step(32'(level), target, 32'(FADE_STEP), 32'(MAX)));

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq  = level * level;
  assign level_eff = PWM_BITS'(level_sq >> PWM_BITS);
`else
  assign level_eff = level;
`endif

  // Full scale is forced solid on: the compare alone would leave one dark
  // slot per PWM period (and more with gamma).
  always_ff @(posedge hwclk) begin
    if (rst) begin
      level <= '0;
      pin   <= 1'b0;
    end else begin
      if (tick) begin
        level <= level_next;
      end
      pin <= enable & ((level == MAX) | (level_eff > pwm_cnt));
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns hard per-LED on/off toggles into linear PWM fades.
//   hwclk     : system clock
//   rst       : synchronous active-high reset
//   enable    : 1 = run; 0 = freeze fades (levels, prescaler) and blank pins
//   led_in    : target pattern, 1 = fade up, 0 = fade down
//   led_out   : registered PWM drive to the LED pins
//   fade_tick : one-cycle strobe marking each fade step
// Optional build macro LED_PWM_FADER_GAMMA_EN (see led_fade_channel).
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int FADE_DIV  = 16384,
  parameter int FADE_STEP = 4
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                fade_tick
);

  localparam int              PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;

  // pwm_cnt free-runs even while disabled; prescaler and tick only advance
  // while enabled so fades resume exactly where they stopped.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      fade_tick <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (enable) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          fade_tick <= 1'b1;
        end else begin
          prescaler <= prescaler + PRE_W'(1);
          fade_tick <= 1'b0;
        end
      end else begin
        fade_tick <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .hwclk  (hwclk),
      .rst    (rst),
      .enable (enable),
      .tick   (fade_tick),
      .target (led_in[i]),
      .pwm_cnt(pwm_cnt),
      .pin    (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed + randomized bench for led_pwm_fader at
// NUM_LEDS=8, PWM_BITS=4, FADE_DIV=4, FADE_STEP=4 (MAX=15).
module tb_led_pwm_fader;

  localparam int N    = 8;
  localparam int PB   = 4;
  localparam int FD   = 4;
  localparam int FS   = 4;
  localparam int MAXV = (1 << PB) - 1;
  localparam int PER  = 1 << PB;

  // clock / reset
  logic         hwclk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] led_in;
  logic [N-1:0] led_out;
  logic         fade_tick;

  always #5 hwclk = ~hwclk;

  led_pwm_fader #(
    .NUM_LEDS (N),
    .PWM_BITS (PB),
    .FADE_DIV (FD),
    .FADE_STEP(FS)
  ) dut (
    .hwclk    (hwclk),
    .rst      (rst),
    .enable   (enable),
    .led_in   (led_in),
    .led_out  (led_out),
    .fade_tick(fade_tick)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model: time counted in cycles since reset, levels as integers
  int           m_since;   // enabled cycles since reset
  int           m_cycles;  // all cycles since reset
  int           m_lvl[N];
  logic [N-1:0] m_out;
  logic         m_tick;

  function automatic int eff(input int l);
`ifdef LED_PWM_FADER_GAMMA_EN
    return (l * l) / PER;
`else
    return l;
`endif
  endfunction

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < 0) return 0;
    return v;
  endfunction

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    logic [N-1:0] nout;
    int           pwm;
    if (rst) begin
      m_since  = 0;
      m_cycles = 0;
      m_out    = '0;
      m_tick   = 1'b0;
      for (int i = 0; i < N; i++) m_lvl[i] = 0;
      return;
    end
    pwm = m_cycles % PER;
    for (int i = 0; i < N; i++)
      nout[i] = enable && (m_lvl[i] == MAXV || eff(m_lvl[i]) > pwm);
    if (m_tick)
      for (int i = 0; i < N; i++)
        m_lvl[i] = clamp(led_in[i] ? m_lvl[i] + FS : m_lvl[i] - FS);
    // a tick lands every FD enabled cycles
    if (enable) begin
      m_since = m_since + 1;
      m_tick  = (m_since % FD) == 0;
    end else begin
      m_tick = 1'b0;
    end
    m_cycles = m_cycles + 1;
    m_out    = nout;
  endtask

  // scoreboard comparison against the model
  task automatic check(input string tag);
    vectors++;
    assert (led_out === m_out) else begin
      miscompares++;
      $error("FAIL %s led_out observed %b expected %b", tag, led_out, m_out);
    end
    vectors++;
    assert (fade_tick === m_tick) else begin
      miscompares++;
      $error("FAIL %s fade_tick observed %b expected %b", tag, fade_tick, m_tick);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge hwclk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic count_to_tick(input string tag);
    int k;
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(tag);
      if (fade_tick === 1'b1) begin
        k = c;
        break;
      end
    end
    vectors++;
    assert (k == FD) else begin
      miscompares++;
      $error("FAIL %s first tick after cycles observed %0d expected %0d", tag, k, FD);
    end
  endtask

  initial begin
    bit found;
    m_since = 0; m_cycles = 0; m_out = '0; m_tick = 1'b0;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;

    // 1. reset with all targets high
    rst = 1'b1; enable = 1'b1; led_in = 8'hFF;
    repeat (3) cycle("reset");
    rst = 1'b0; led_in = 8'h01;
    count_to_tick("first_tick");

    // 2. fade up to saturation on channel 0
    repeat (6 * FD) cycle("fade_up");
    for (int c = 0; c < PER; c++) begin
      cycle("solid_on");
      vectors++;
      assert (led_out === 8'h01) else begin
        miscompares++;
        $error("FAIL solid_on led_out observed %b expected %b", led_out, 8'h01);
      end
    end

    // 4. fade down to zero, no wrap
    led_in = 8'h00;
    repeat (6 * FD) cycle("fade_down");
    for (int c = 0; c < PER; c++) begin
      cycle("solid_off");
      vectors++;
      assert (led_out === 8'h00) else begin
        miscompares++;
        $error("FAIL solid_off led_out observed %b expected %b", led_out, 8'h00);
      end
    end

    // 5. reset on a tick cycle while level is 8
    led_in = 8'h01;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle("seek_mid");
      if (m_tick && m_lvl[0] == 8) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL seek_mid reached observed %0d expected %0d", found, 1);
    end
    rst = 1'b1;
    cycle("rst_mid");
    vectors++;
    assert (led_out === 8'h00 && fade_tick === 1'b0) else begin
      miscompares++;
      $error("FAIL rst_mid out/tick observed %b/%b expected 00000000/0", led_out, fade_tick);
    end
    rst = 1'b0;
    count_to_tick("restart_tick");

    // 6. freeze at level 8 with enable low
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle("seek_8");
      if (!m_tick && m_lvl[0] == 8) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL seek_8 reached observed %0d expected %0d", found, 1);
    end
    enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle("disabled");
      vectors++;
      assert (led_out === 8'h00 && fade_tick === 1'b0) else begin
        miscompares++;
        $error("FAIL disabled out/tick observed %b/%b expected 00000000/0", led_out, fade_tick);
      end
    end
    enable = 1'b1;
    repeat (40) cycle("reenable");

    // randomized: slowly changing patterns, occasional disable and reset
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) led_in = N'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      cycle("random");
    end
    rst = 1'b0; enable = 1'b1;
    repeat (PER) cycle("tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the counter-driven LED blinker.
- Takes its per-LED on/off pattern and turns each hard toggle into a smooth linear fade-in/fade-out using per-channel brightness levels and a shared PWM counter.
- Sits between the pattern source and the board LED pins; all inputs are on the same hwclk domain.

Parameters:
- NUM_LEDS, 8, number of LED channels.
- PWM_BITS, 8, width of the PWM counter and of each brightness level; MAX = 2^PWM_BITS-1.
- FADE_DIV, 16384, hwclk cycles per fade step; legal range ≥2.
- FADE_STEP, 4, level increment/decrement per fade step; legal range 1..MAX.

Ports:
- hwclk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze fades and blank outputs.
- led_in  in  NUM_LEDS  target pattern, 1 = fade toward MAX, 0 = fade toward 0.
- led_out  out  NUM_LEDS  PWM drive to LED pins, registered.
- fade_tick  out  1  one-cycle strobe marking each fade step (debug/chaining).

Behaviour:
- Interface: one clock, hwclk. Reset rst is synchronous and active-high.
- Reset values: prescaler=0, pwm_cnt=0, every level=0, led_out=0, fade_tick=0.
- rst dominates every other event in the same cycle, including a coincident fade_tick and any fade in progress. The cycle after rst deasserts, counting restarts from 0.
- Prescaler: counts 0..FADE_DIV-1 while enable=1 and holds while enable=0.
  - fade_tick is registered and is 1 in the cycle after prescaler==FADE_DIV-1. The prescaler wraps to 0 at that point.
  - First tick after reset release therefore occurs FADE_DIV cycles later.
- pwm_cnt: PWM_BITS wide, increments every cycle regardless of enable, wraps MAX→0.
- Per-channel level update happens only in a cycle where fade_tick=1. led_in[i] is sampled in that cycle; values between ticks are ignored.
  - led_in[i]=1: level = min(level+FADE_STEP, MAX). Sum is computed in PWM_BITS+1 bits, saturating and never wrapping.
  - led_in[i]=0: level = max(level-FADE_STEP, 0), saturating and never wrapping.
- Effective level: level_eff = level (no GAMMA_EN).
- Output: led_out[i] <= enable & ((level==MAX) | (level_eff > pwm_cnt)).
  - Latency is 1 cycle from level/pwm_cnt to pin.
  - level=0 gives solid off; level=MAX gives solid on; otherwise duty = level_eff/2^PWM_BITS.
- enable=0: led_out goes to 0 on the next edge. Levels and prescaler are held; pwm_cnt keeps running. On re-enable, fading resumes from the held levels.
- Full-scale fade time = ceil(MAX/FADE_STEP) ticks (64 ticks at defaults, ≈87 ms at 12 MHz).
- No synchronizers are included; led_in must be synchronous to hwclk.

Optional Feature:
- Macro: LED_PWM_FADER_GAMMA_EN.
- Defined: level_eff = (level*level) >> PWM_BITS, using a 2*PWM_BITS-bit product, combinational. Output latency is unchanged. level==MAX still forces solid on. This gives perceptually linear fades.
- Undefined: level_eff = level; no multiplier is synthesised.

Decomposition:
- Shared package led_pkg:
  - PWM_BITS default and MAX constant.
  - level_t typedef (PWM_BITS wide).
  - function sat_step(level, up, step) returning the saturated next level.
- Sub-module led_fade_channel, instantiated NUM_LEDS times. Contains one level register, the saturating update, optional gamma, and the registered compare.
- Prescaler and pwm_cnt stay in the top level and are shared by all channels.

Test Plan (bench params PWM_BITS=4, FADE_DIV=4, FADE_STEP=4, MAX=15):
1. Reset: hold rst 3 cycles with led_in=8'hFF → led_out=0, fade_tick=0 throughout. First fade_tick 4 cycles after release.
2. Fade up: led_in[0]=1 held → level0 = 4, 8, 12, 15 on successive ticks, stays at 15 (saturation). led_out[0] solid 1 once at 15.
3. Duty: level frozen at 8 (led_in toggled so net is 0) → led_out high exactly 8 of every 16 cycles, during pwm_cnt 0..7. With LED_PWM_FADER_GAMMA_EN: level 8 → 4 of 16 cycles.
4. Fade down: at level 15 set led_in[0]=0 → 11, 7, 3, 0, then holds 0 (no underflow wrap). led_out[0] solid 0.
5. Reset mid-fade: assert rst on a fade_tick cycle at level 8 → next cycle level=0, led_out=0, no update applied. Prescaler restarts from 0.
6. Enable: at level 8 drop enable for 20 cycles → led_out=0, level stays 8, no fade_tick. Re-enable → duty 8/16 resumes, and the next tick arrives after the remaining prescaler count.
